im_loader: RTL and testbench

- Writer side of the instruction memory: receives a program as a byte stream and writes 32-bit words into the writable instruction memory over its write port.
- Holds the core in reset while loading; releases it when the load completes.
- Sits between the boot byte source (UART RX or testbench) and the instruction memory write port.
- The instruction memory keeps its read port (byte address, word index = addr >> 2) unchanged.

---
 rtl/rv_mem_pkg.sv | 21 ++
 rtl/byte_to_word.sv | 38 +++
 rtl/im_loader.sv | 153 +++++++++++++++
 tb/tb_im_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared instruction-memory definitions used by the boot loader and the
// instruction memory, so both agree on depth, address width and word size.
package rv_mem_pkg;

  localparam int IM_DEPTH   = 128;  // words
  localparam int IM_ADDR_W  = 16;   // byte-address width
  localparam int WORD_BYTES = 4;

  // Loader FSM states. ST_CHK is only entered when the checksum option is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6,
    ST_CHK    = 3'd7
  } ld_state_e;

endpackage

// File: rtl/byte_to_word.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in
// word[7:0]. word_valid marks the cycle in which the last byte is accepted;
// the complete word is visible on 'word' from the following cycle.
module byte_to_word
  import rv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] byte_cnt;

  // Last byte of the word is being accepted this cycle.
  always_comb begin
    word_valid = byte_valid && (byte_cnt == CNT_W'(WORD_BYTES - 1));
  end

  // Byte counter and assembly register; clr restarts at byte 0 for a new load.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order between always blocks.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (byte_valid) begin
      word[8*byte_cnt +: 8] <= byte_in;
      byte_cnt              <= word_valid ? '0 : byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory boot loader. Receives "N (16-bit LE) + N words (32-bit LE)"
// as a byte stream, writes each word to the instruction memory and keeps the
// core held until the load completes.
// Build option: define IM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum
// byte over all payload bytes (count bytes excluded).
module im_loader
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DEPTH  = IM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // Word index must reach DEPTH itself, hence one extra bit.
  localparam int IDX_W = $clog2(DEPTH) + 1;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam ld_state_e END_ST = ST_CHK;
`else
  localparam ld_state_e END_ST = ST_DONE;
`endif

  ld_state_e        state, state_nx;
  logic [15:0]      len;
  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             start_ok;
  logic             last_word;
  logic             word_valid;
  logic [31:0]      word;
  logic [15:0]      len_full;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]       chk;
`endif

  // Handshake and decision helpers shared by the FSM and the datapath.
  always_comb begin
    xfer      = in_valid && in_ready;
    start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    len_full  = {in_data, len[7:0]};
    last_word = (16'(idx) + 16'd1) == len;
  end

  byte_to_word u_b2w (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .byte_valid (state == ST_DATA && xfer),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (start) state_nx = ST_LEN_LO;
      ST_LEN_LO: if (xfer)  state_nx = ST_LEN_HI;
      ST_LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0)              state_nx = END_ST;
          else if (len_full > 16'(DEPTH))     state_nx = ST_ERR;
          else                                state_nx = ST_DATA;
        end
      end
      ST_DATA:   if (word_valid) state_nx = ST_WRITE;
      ST_WRITE:  state_nx = last_word ? END_ST : ST_DATA;
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CHK:    if (xfer) state_nx = (in_data == chk) ? ST_DONE : ST_ERR;
`endif
      ST_DONE,
      ST_ERR:    if (start) state_nx = ST_LEN_LO;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Length, word index and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      len <= '0;
      idx <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      chk <= '0;
`endif
    end else begin
      if (start_ok) begin
        idx <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
        chk <= '0;
`endif
      end
      if (state == ST_LEN_LO && xfer) len[7:0]  <= in_data;
      if (state == ST_LEN_HI && xfer) len[15:8] <= in_data;
      if (state == ST_WRITE)          idx       <= idx + IDX_W'(1);
`ifdef IM_LOADER_CHECKSUM_EN
      if (state == ST_DATA && xfer)   chk       <= chk ^ in_data;
`endif
    end
  end

  // Moore outputs decoded from the state; WRITE never asserts in_ready.
  always_comb begin
    in_ready = 1'b0;
    we       = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA:  in_ready = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CHK:   in_ready = 1'b1;
`endif
      ST_WRITE: we = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERR:   err = 1'b1;
      default:  ;
    endcase
  end

  // Write address is the word index in bytes, zero-extended.
  always_comb begin
    waddr              = '0;
    waddr[IDX_W+1:0]   = {idx, 2'b00};
    wdata              = word;
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed multi-cycle sequences plus a
// table of randomized loads compared against a simple program model.
module tb_im_loader;
  import rv_mem_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, start, in_valid;
  logic [7:0]           in_data;
  logic                 in_ready, we, cpu_hold, done, err;
  logic [IM_ADDR_W-1:0] waddr;
  logic [31:0]          wdata;

  int n_cmp   = 0;
  int n_fail  = 0;
  int overlap = 0;

  logic [IM_ADDR_W-1:0] got_addr[$];
  logic [31:0]          got_data[$];
  logic [31:0]          words[$];   // expected program, word i at byte address 4*i

  typedef struct {
    logic [15:0] n;
    int          gap_max;
    logic        exp_done;
    logic        exp_err;
    logic        exp_hold;
  } vec_t;

  vec_t tbl[9];

  im_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we) begin
      got_addr.push_back(waddr);
      got_data.push_back(wdata);
    end
    if (we && in_ready) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after a random gap; returns at the negedge after it was taken.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int tries;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    while (!in_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: byte %0h not accepted, in_ready %0b required 1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int exp_n);
    check({tag, "_wcount"}, 64'(got_addr.size()), 64'(exp_n));
    for (int i = 0; i < exp_n && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(i * WORD_BYTES));
      check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(words[i]));
    end
  endtask

  // Random program of n words; the model expects all n written when n fits.
  task automatic run_load(input logic [15:0] n, input int gap_max);
    logic [7:0]  x;
    logic [31:0] w;
    int          nw;
    words.delete();
    clear_log();
    nw = (n <= 16'(IM_DEPTH)) ? int'(n) : 0;
    for (int i = 0; i < nw; i++) words.push_back($urandom);
    pulse_start();
    send_byte(n[7:0], gap_max);
    send_byte(n[15:8], gap_max);
    x = 8'h00;
    for (int i = 0; i < nw; i++) begin
      w = words[i];
      for (int b = 0; b < WORD_BYTES; b++) begin
        send_byte(w[8*b +: 8], gap_max);
        x = x ^ w[8*b +: 8];
      end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    if (n <= 16'(IM_DEPTH)) send_byte(x, gap_max);
`endif
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] prog[12];
    logic [7:0] x;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // ---- reset state ----
    check("rst_in_ready", in_ready, 0);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // ---- directed N=3 load, with an ignored start pulse mid-load ----
    prog = '{8'h13, 8'h04, 8'h30, 8'h00, 8'h93, 8'h04, 8'h10, 8'h00,
             8'h13, 8'h09, 8'h00, 8'h01};
    words.delete();
    words.push_back(32'h00300413);
    words.push_back(32'h00100493);
    words.push_back(32'h01000913);
    clear_log();
    pulse_start();
    check("n3_hold_loading", cpu_hold, 1);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send_byte(prog[i], 0);
      x = x ^ prog[i];
    end
    check("n3_we_latency", we, 1);
    check("n3_w0_waddr", waddr, 0);
    check("n3_w0_wdata", wdata, 32'h00300413);
    check("n3_ready_in_write", in_ready, 0);
    @(negedge clk);
    pulse_start();
    for (int i = 4; i < 12; i++) begin
      send_byte(prog[i], 0);
      x = x ^ prog[i];
    end
`ifdef IM_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("n3_wait_chk", done, 0);
    send_byte(x, 0);
`endif
    repeat (2) @(negedge clk);
    check_writes("n3", 3);
    check("n3_done", done, 1);
    check("n3_hold", cpu_hold, 0);
    check("n3_err", err, 0);
    // Stray bytes in DONE are refused.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check("done_stray_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("done_stray_wcount", 64'(got_addr.size()), 3);
    check("done_stray_done", done, 1);

    // ---- table of randomized loads (ERR entries followed by recovery) ----
    tbl[0] = '{16'd1,     0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16'd129,   0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{16'd1,     1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'd10,    5, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h0100,  0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{16'd2,     2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'd128,   1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{16'hFFFF,  0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{16'd7,     3, 1'b1, 1'b0, 1'b0};
    for (int v = 0; v < 9; v++) begin
      run_load(tbl[v].n, tbl[v].gap_max);
      check($sformatf("vec%0d_done", v), done, tbl[v].exp_done);
      check($sformatf("vec%0d_err", v), err, tbl[v].exp_err);
      check($sformatf("vec%0d_hold", v), cpu_hold, tbl[v].exp_hold);
      check($sformatf("vec%0d_ready", v), in_ready, 0);
      check_writes($sformatf("vec%0d", v), tbl[v].exp_err ? 0 : int'(tbl[v].n));
    end

    // ---- reset in the middle of word 1 ----
    words.delete();
    words.push_back(32'hDEADBEEF);
    words.push_back(32'h0BADF00D);
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_byte(8'h0D, 0);
    send_byte(8'hF0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hold", cpu_hold, 1);
    check("midrst_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    repeat (3) @(negedge clk);
    check_writes("midrst", 1);
    run_load(16'd2, 1);
    check_writes("reload", 2);
    check("reload_done", done, 1);

    // ---- N=0 ----
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    check("n0_wait_chk", done, 0);
    send_byte(8'h00, 0);
`endif
    @(negedge clk);
    check("n0_done", done, 1);
    check("n0_hold", cpu_hold, 0);
    check("n0_wcount", 64'(got_addr.size()), 0);

`ifdef IM_LOADER_CHECKSUM_EN
    // ---- checksum: good then bad for a single word ----
    words.delete();
    words.push_back(32'h00300413);
    for (int t = 0; t < 2; t++) begin
      clear_log();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h04, 0);
      send_byte(8'h30, 0);
      send_byte(8'h00, 0);
      send_byte((t == 0) ? 8'h27 : 8'h00, 0);
      repeat (2) @(negedge clk);
      check($sformatf("chk%0d_done", t), done, (t == 0) ? 1 : 0);
      check($sformatf("chk%0d_err", t), err, (t == 0) ? 0 : 1);
      check_writes($sformatf("chk%0d", t), 1);
    end
`endif

    check("no_we_with_ready", 64'(overlap), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
